// File: rtl/rv32i_fetch_queue.sv
// rv32i_fetch_queue: prefetch PC, one-deep in-flight tracker and DEPTH-entry {ir, npc} queue.
// Define FETCH_STATS_EN to add saturating pop/flush counters (stat_fetch, stat_flush).
module rv32i_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        RN,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        br_en,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_ir,
    output logic [31:0] if_npc
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stat_fetch,
    output logic [15:0] stat_flush
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   fl_addr_q, fl_addr_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   ir_q  [DEPTH];
    logic [31:0]   npc_q [DEPTH];
    logic          push, pop;

    // A redirect or reset cancels both the push of the returning word and any pop.
    always_comb begin
        push      = inflight_q && !br_en && !RN;
        pop       = if_valid && !stall && !br_en && !RN;
        imem_req  = !RN && !br_en && (cnt_q + CW'(inflight_q) < CW'(DEPTH));
        imem_addr = pc_q;
        if_valid  = cnt_q != '0;
        if_ir     = if_valid ? ir_q[rd_q] : '0;
        if_npc    = if_valid ? npc_q[rd_q] : '0;
    end

    always_comb begin
        pc_d       = br_en ? br_target : (imem_req ? pc_q + 32'd1 : pc_q);
        inflight_d = imem_req;
        fl_addr_d  = imem_req ? pc_q : fl_addr_q;
        wr_d       = br_en ? '0 : (push ? wr_q + PW'(1) : wr_q);
        rd_d       = br_en ? '0 : (pop ? rd_q + PW'(1) : rd_q);
        cnt_d      = br_en ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (RN) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            fl_addr_q  <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            fl_addr_q  <= fl_addr_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ir_q[wr_q]  <= imem_data;
            npc_q[wr_q] <= fl_addr_q + 32'd1;
        end
    end

    // Request throttling keeps occupancy plus in-flight within DEPTH, so this never fires.
    always_ff @(posedge clk) begin
        if (push && !pop)
            assert (cnt_q != CW'(DEPTH));
    end

`ifdef FETCH_STATS_EN
    logic [15:0] stat_fetch_q, stat_flush_q;

    always_ff @(posedge clk) begin
        if (RN) begin
            stat_fetch_q <= '0;
            stat_flush_q <= '0;
        end else begin
            if (pop && stat_fetch_q != 16'hFFFF)
                stat_fetch_q <= stat_fetch_q + 16'd1;
            if (br_en && stat_flush_q != 16'hFFFF)
                stat_flush_q <= stat_flush_q + 16'd1;
        end
    end

    assign stat_fetch = stat_fetch_q;
    assign stat_flush = stat_flush_q;
`endif
endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// tb_rv32i_fetch_queue: scoreboarded checks of fetch order, redirect timing, stall, reset and PC wrap.
module tb_rv32i_fetch_queue;
    logic        clk = 1'b0;
    logic        RN, imem_req, br_en, stall, if_valid;
    logic [31:0] imem_addr, imem_data, br_target, if_ir, if_npc;
    logic        rst2, req2, valid2;
    logic        br2 = 1'b0, stall2 = 1'b0;
    logic [31:0] addr2, data2, ir2, npc2;
    logic [31:0] tgt2 = 32'd0;
`ifdef FETCH_STATS_EN
    logic [15:0] stat_fetch, stat_flush, stat_fetch2, stat_flush2;
`endif

    int          checks = 0, errors = 0;
    logic [31:0] exp_addr;
    int          pops, flushes, since_br;

    always #5 clk = ~clk;

    rv32i_fetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
        .clk(clk), .RN(RN), .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .br_en(br_en), .br_target(br_target), .stall(stall),
        .if_valid(if_valid), .if_ir(if_ir), .if_npc(if_npc)
`ifdef FETCH_STATS_EN
        , .stat_fetch(stat_fetch), .stat_flush(stat_flush)
`endif
    );

    rv32i_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFFFFFE)) dut2 (
        .clk(clk), .RN(rst2), .imem_req(req2), .imem_addr(addr2), .imem_data(data2),
        .br_en(br2), .br_target(tgt2), .stall(stall2),
        .if_valid(valid2), .if_ir(ir2), .if_npc(npc2)
`ifdef FETCH_STATS_EN
        , .stat_fetch(stat_fetch2), .stat_flush(stat_flush2)
`endif
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a + 32'h10;
    endfunction

    // Memory answers one cycle after a request; poison otherwise so unrequested pushes show up.
    always @(posedge clk) imem_data <= imem_req ? mem_f(imem_addr) : 32'hDEADBEEF;
    always @(posedge clk) data2 <= req2 ? mem_f(addr2) : 32'hDEADBEEF;

    // Drives one cycle and advances the reference: a redirect restarts the expected stream,
    // otherwise a visible head with stall low is consumed.
    task automatic tick(input logic st, input logic br, input logic [31:0] tgt);
        stall = st;
        br_en = br;
        br_target = tgt;
        if (br) begin
            exp_addr = tgt;
            flushes++;
            since_br = 0;
        end else if (if_valid && !st) begin
            exp_addr = exp_addr + 32'd1;
            pops++;
        end
        @(negedge clk);
        br_en = 1'b0;
        if (since_br < 1000) since_br++;
        #1;
    endtask

    task automatic test_reset;
        RN = 1'b1;
        stall = 1'b0;
        br_en = 1'b0;
        br_target = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: imem_req=%b want 0", imem_req);
        end
        checks++;
        if (if_valid !== 1'b0 || if_ir !== 32'd0 || if_npc !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: valid=%b ir=%h npc=%h want 0/0/0", if_valid, if_ir, if_npc);
        end
        checks++;
        if (imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_pc: addr=%h want 0", imem_addr);
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (stat_fetch !== 16'd0 || stat_flush !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats: fetch=%0d flush=%0d want 0/0", stat_fetch, stat_flush);
        end
`endif
    endtask

    task automatic test_stream;
        RN = 1'b0;
        exp_addr = 32'd0;
        pops = 0;
        flushes = 0;
        since_br = 1000;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
        tick(0, 0, 0);
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_edge: valid=%b want 0", if_valid);
        end
        tick(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_ir !== 32'h10 + 32'(i) || if_npc !== 32'(i + 1)) begin
                errors++;
                $display("FAIL stream%0d: valid=%b ir=%h npc=%h want 1/%h/%h",
                         i, if_valid, if_ir, if_npc, 32'h10 + 32'(i), i + 1);
            end
            tick(0, 0, 0);
        end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_ir !== mem_f(exp_addr) || if_npc !== exp_addr + 32'd1) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b ir=%h npc=%h want 1/%h/%h",
                         i, if_valid, if_ir, if_npc, mem_f(exp_addr), exp_addr + 32'd1);
            end
            tick(1, 0, 0);
        end
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_full: req=%b valid=%b want 0/1", imem_req, if_valid);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_ir !== mem_f(exp_addr) || if_npc !== exp_addr + 32'd1) begin
                errors++;
                $display("FAIL stall_release%0d: valid=%b ir=%h npc=%h want 1/%h/%h",
                         i, if_valid, if_ir, if_npc, mem_f(exp_addr), exp_addr + 32'd1);
            end
            tick(0, 0, 0);
        end
    endtask

    task automatic test_branch;
        repeat (6) tick(1, 0, 0);
        tick(0, 0, 0);
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL br_pre_req: req=%b want 1", imem_req);
        end
        tick(1, 0, 0);
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL br_pre_inflight: req=%b valid=%b want 0/1", imem_req, if_valid);
        end
        tick(1, 1, 32'd14);
        checks++;
        if (if_valid !== 1'b0 || if_ir !== 32'd0 || if_npc !== 32'd0) begin
            errors++;
            $display("FAIL br_flush: valid=%b ir=%h npc=%h want 0/0/0", if_valid, if_ir, if_npc);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd14) begin
            errors++;
            $display("FAIL br_refetch: req=%b addr=%h want 1/e", imem_req, imem_addr);
        end
        tick(0, 0, 0);
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_gap: valid=%b want 0", if_valid);
        end
        tick(0, 0, 0);
        checks++;
        if (if_valid !== 1'b1 || if_ir !== 32'h1E || if_npc !== 32'd15) begin
            errors++;
            $display("FAIL br_target: valid=%b ir=%h npc=%h want 1/1e/f", if_valid, if_ir, if_npc);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_ir !== mem_f(exp_addr) || if_npc !== exp_addr + 32'd1) begin
                errors++;
                $display("FAIL br_stream%0d: valid=%b ir=%h npc=%h want 1/%h/%h",
                         i, if_valid, if_ir, if_npc, mem_f(exp_addr), exp_addr + 32'd1);
            end
            tick(0, 0, 0);
        end
    endtask

    task automatic test_flush_priority;
        for (int v = 0; v < 2; v++) begin
            logic [31:0] tgt;
            tgt = 32'(40 + 20 * v);
            checks++;
            if (if_valid !== 1'b1) begin
                errors++;
                $display("FAIL prio_pre%0d: valid=%b want 1", v, if_valid);
            end
            tick(v == 0, 1, tgt);
            checks++;
            if (if_valid !== 1'b0) begin
                errors++;
                $display("FAIL prio_flush%0d: valid=%b want 0", v, if_valid);
            end
            tick(0, 0, 0);
            tick(0, 0, 0);
            checks++;
            if (if_valid !== 1'b1 || if_ir !== mem_f(tgt) || if_npc !== tgt + 32'd1) begin
                errors++;
                $display("FAIL prio_target%0d: valid=%b ir=%h npc=%h want 1/%h/%h",
                         v, if_valid, if_ir, if_npc, mem_f(tgt), tgt + 32'd1);
            end
            tick(0, 0, 0);
            tick(0, 0, 0);
        end
    endtask

    task automatic test_reset_mid;
        repeat (3) tick(1, 0, 0);
        RN = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req_low: req=%b want 0", imem_req);
        end
        @(negedge clk);
        RN = 1'b0;
        #1;
        exp_addr = 32'd0;
        pops = 0;
        flushes = 0;
        since_br = 1000;
        checks++;
        if (if_valid !== 1'b0 || if_ir !== 32'd0 || if_npc !== 32'd0) begin
            errors++;
            $display("FAIL rst_clear: valid=%b ir=%h npc=%h want 0/0/0", if_valid, if_ir, if_npc);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_restart: req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (stat_fetch !== 16'd0 || stat_flush !== 16'd0) begin
            errors++;
            $display("FAIL rst_stats: fetch=%0d flush=%0d want 0/0", stat_fetch, stat_flush);
        end
`endif
        tick(1, 0, 0);
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_gap: valid=%b want 0", if_valid);
        end
        tick(1, 0, 0);
        checks++;
        if (if_valid !== 1'b1 || if_ir !== 32'h10 || if_npc !== 32'd1) begin
            errors++;
            $display("FAIL rst_first: valid=%b ir=%h npc=%h want 1/10/1", if_valid, if_ir, if_npc);
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            logic [31:0] a;
            a = 32'hFFFFFFFE + 32'(k);
            checks++;
            if (req2 !== 1'b1 || addr2 !== a) begin
                errors++;
                $display("FAIL wrap_addr%0d: req=%b addr=%h want 1/%h", k, req2, addr2, a);
            end
            checks++;
            if (k < 2 && valid2 !== 1'b0) begin
                errors++;
                $display("FAIL wrap_gap%0d: valid=%b want 0", k, valid2);
            end else if (k >= 2 && (valid2 !== 1'b1 || ir2 !== mem_f(a - 32'd2) || npc2 !== a - 32'd1)) begin
                errors++;
                $display("FAIL wrap_head%0d: valid=%b ir=%h npc=%h want 1/%h/%h",
                         k, valid2, ir2, npc2, mem_f(a - 32'd2), a - 32'd1);
            end
            @(negedge clk);
            #1;
        end
        rst2 = 1'b1;
    endtask

    task automatic test_random;
        logic        st, br;
        logic [31:0] tgt;
        RN = 1'b1;
        @(negedge clk);
        RN = 1'b0;
        stall = 1'b0;
        br_en = 1'b0;
        #1;
        exp_addr = 32'd0;
        pops = 0;
        flushes = 0;
        since_br = 1000;
        for (int n = 0; n < 500; n++) begin
            if (since_br == 1 || since_br == 2) begin
                checks++;
                if (if_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_gap%0d: valid=%b want 0", n, if_valid);
                end
            end else if (since_br == 3) begin
                checks++;
                if (if_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_resume%0d: valid=%b want 1", n, if_valid);
                end
            end
            checks++;
            if (if_valid === 1'b1) begin
                if (if_ir !== mem_f(exp_addr) || if_npc !== exp_addr + 32'd1) begin
                    errors++;
                    $display("FAIL rnd_head%0d: ir=%h npc=%h want %h/%h",
                             n, if_ir, if_npc, mem_f(exp_addr), exp_addr + 32'd1);
                end
            end else if (if_ir !== 32'd0 || if_npc !== 32'd0) begin
                errors++;
                $display("FAIL rnd_empty%0d: ir=%h npc=%h want 0/0", n, if_ir, if_npc);
            end
            st  = $urandom_range(0, 9) < 3;
            br  = $urandom_range(0, 29) == 0;
            tgt = $urandom_range(0, 1) == 1 ? $urandom : 32'hFFFFFFFD + 32'($urandom_range(0, 2));
            tick(st, br, tgt);
        end
        checks++;
        if (pops < 100) begin
            errors++;
            $display("FAIL rnd_progress: pops=%0d want >=100", pops);
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (stat_fetch !== 16'(pops) || stat_flush !== 16'(flushes)) begin
            errors++;
            $display("FAIL rnd_stats: fetch=%0d flush=%0d want %0d/%0d", stat_fetch, stat_flush, pops, flushes);
        end
`endif
    endtask

    initial begin
        RN = 1'b1;
        rst2 = 1'b1;
        stall = 1'b0;
        br_en = 1'b0;
        br_target = '0;
        test_reset;
        test_stream;
        test_stall;
        test_branch;
        test_flush_priority;
        test_reset_mid;
        test_wrap;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32i_fetch_queue.md
RV32I_FETCH_QUEUE -- requirements
Module: rv32i_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'd0, meaning the word address of the first fetch after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RN, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port imem_req, output, 1, meaning the instruction memory samples imem_addr this cycle.
REQ-006 SHALL have port imem_addr, output, 32, the word address of the instruction to fetch.
REQ-007 SHALL have port imem_data, input, 32, the instruction word, valid exactly one cycle after its request.
REQ-008 SHALL have port br_en, input, 1, a redirect request from the execute stage.
REQ-009 SHALL have port br_target, input, 32, the redirect word address.
REQ-010 SHALL have port stall, input, 1, meaning decode cannot accept an instruction this cycle.
REQ-011 SHALL have port if_valid, output, 1, meaning if_ir and if_npc hold a valid instruction.
REQ-012 SHALL have port if_ir, output, 32, the instruction at the queue head.
REQ-013 SHALL have port if_npc, output, 32, the fetch word address of the head plus 1.

Function
REQ-014 SHALL keep a fetch PC, a DEPTH-entry FIFO of {ir, npc}, and a single in-flight flag with its address.
REQ-015 SHALL drive imem_addr = PC and assert imem_req combinationally when RN is low and (occupancy + in-flight) < DEPTH.
REQ-016 SHALL, on an edge with imem_req high, set in-flight and increment PC by 1; PC SHALL wrap from 32'hFFFFFFFF to 0.
REQ-017 SHALL, on the edge after a request, push {imem_data, request address + 1} into the FIFO, unless that request was squashed.
REQ-018 SHALL drive if_valid = FIFO not empty, with if_ir and if_npc equal to the head entry and zero when empty.
REQ-019 SHALL pop the head on an edge where if_valid is high and stall is low.
REQ-020 SHALL, when push and pop occur on the same edge, leave occupancy unchanged; this SHALL be legal at full.
REQ-021 SHALL never overflow the FIFO; any push that would overflow is a design error and SHALL be flagged by an assertion.
REQ-022 SHALL, on an edge with br_en high: set PC to br_target, empty the FIFO, squash any in-flight response, and deassert imem_req for that cycle.
REQ-023 br_en SHALL take priority over pop, push and stall on the same edge.
REQ-024 SHALL raise if_valid for br_target exactly two edges after the br_en edge, with if_npc = br_target + 1.
REQ-025 SHALL reach steady-state throughput of one instruction per cycle when stall is low.
REQ-026 SHALL wrap FIFO read and write pointers modulo DEPTH.

Reset
REQ-027 SHALL, on an edge with RN high, set PC=RESET_PC, empty the FIFO, clear in-flight, and hold if_valid=0, if_ir=0, if_npc=0, imem_req=0.
REQ-028 SHALL, when RN asserts mid-operation, discard all queued and in-flight instructions.
REQ-029 SHALL, after RN falls, first request RESET_PC on the first edge and raise if_valid after the second edge.

Configuration
REQ-030 SHALL, with macro FETCH_STATS_EN defined, add outputs stat_fetch[15:0] and stat_flush[15:0].
REQ-031 stat_fetch SHALL count pops, stat_flush SHALL count br_en edges; both SHALL saturate at 16'hFFFF and clear on reset.
REQ-032 SHALL, without FETCH_STATS_EN, omit those ports and counters, with all other behaviour identical.

Verification
REQ-033 Reset then release, MEM[0..7]=0x10..0x17, stall=0 -> if_ir 0x10..0x17 on consecutive cycles, if_npc 1..8, first valid after the second edge.
REQ-034 stall=1 for 10 cycles after the first valid -> occupancy 4, imem_req low; on release, 4 queued instructions then a gap-free stream with no loss or duplicate.
REQ-035 br_en=1, br_target=14 while the queue is full and a request is in flight -> if_valid low for 2 edges, then if_ir=MEM[14], if_npc=15, with no stale word.
REQ-036 br_en coincident with stall=1 and a pop -> flush wins; queue empty next cycle; stat_flush increments by 1 with FETCH_STATS_EN.
REQ-037 RESET_PC=32'hFFFFFFFE, stall=0 -> fetch addresses FFFFFFFE, FFFFFFFF, 0, 1; if_npc for FFFFFFFF = 0.
REQ-038 RN pulsed for 1 cycle mid-stream with stall=1 -> all outputs zero next cycle; fetch restarts at RESET_PC.
